uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver, the next generation of the codebase's UART RX path. Samples `rxd_i` at a configurable multiple of the baud rate, locates bit centres, and supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. Each frame lands in a one-entry holding register with a valid/ready handshake, tagged with parity, framing and break status; overrun is flagged. Sits between the baud-tick generator and the UART register/bus interface.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx_os.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_e : receiver FSM states.
//   uart_rx_cfg_t   : per-frame configuration captured at the start edge.
//   parity_bit()    : expected parity bit for a data word (zero-extended).
//   DataWidthMin/Max: legal range of data bits per frame.
package uart_pkg;

  localparam int unsigned DataWidthMin = 5;
  localparam int unsigned DataWidthMax = 9;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop1  = 3'd4,
    StStop2  = 3'd5
  } uart_rx_state_e;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } uart_rx_cfg_t;

  // Zero bits above the real data width do not change the XOR, so any
  // width up to DataWidthMax can be passed zero-extended.
  function automatic logic parity_bit(input logic [DataWidthMax-1:0] data,
                                      input logic                    odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset, both flops load ResetValue
//   d_i    : asynchronous input
//   q_o    : synchronised output (2 clocks latency)
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a one-entry valid/ready holding register.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   baud_tick_i              : one-cycle pulse at Oversample x baud
//   rxd_i                    : asynchronous serial line, idles high
//   parity_en_i/parity_odd_i : parity present / odd (else even)
//   stop2_i                  : two stop bits expected
//   ready_i                  : consumer takes the held frame
//   valid_o, data_o          : held frame present, its data (LSB first on wire)
//   parity_err_o/frame_err_o/break_o : status of the held frame
//   overrun_o                : one-cycle pulse, a completed frame was dropped
//   busy_o                   : receiver FSM not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned Oversample = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_tick_i,
  input  logic                 rxd_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop2_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned TickW = $clog2(Oversample);
  localparam int unsigned BitW  = $clog2(DataWidth + 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(Oversample / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(Oversample - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  logic                 rxd_sync;
  logic                 rxd_prev_q, rxd_prev_d;
  uart_rx_state_e       state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  uart_rx_cfg_t         cfg_q, cfg_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frm_pend_q, frm_pend_d;
  logic                 seen_one_q, seen_one_d;
  logic                 complete;

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 brk_q, brk_d;
  logic                 overrun_q, overrun_d;

  sync_2ff #(.ResetValue(1'b1)) u_sync_rxd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rxd_i),
    .q_o    (rxd_sync)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    rxd_prev_d = rxd_prev_q;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    seen_one_d = seen_one_q;
    complete   = 1'b0;

    // The previous-value register only moves on ticks, so a falling edge
    // anywhere between two ticks is seen at the next tick.
    if (baud_tick_i) begin
      rxd_prev_d = rxd_sync;
      case (state_q)
        StIdle: begin
          if (!rxd_sync && rxd_prev_q) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_pend_d = 1'b0;
            frm_pend_d = 1'b0;
            seen_one_d = 1'b0;
            cfg_d      = '{parity_en: parity_en_i, parity_odd: parity_odd_i,
                           stop2: stop2_i};
          end
        end
        StStart: begin
          if (tick_cnt_q == TickHalf) begin
            if (rxd_sync) begin
              state_d = StIdle;       // glitch: line back high at bit centre
            end else begin
              state_d    = StData;
              tick_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
        default: begin
          if (tick_cnt_q != TickLast) begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end else begin
            tick_cnt_d = '0;
            case (state_q)
              StData: begin
                shift_d    = {rxd_sync, shift_q[DataWidth-1:1]};
                seen_one_d = seen_one_q | rxd_sync;
                if (bit_cnt_q == BitLast) begin
                  bit_cnt_d = '0;
                  state_d   = cfg_q.parity_en ? StParity : StStop1;
                end else begin
                  bit_cnt_d = bit_cnt_q + BitW'(1);
                end
              end
              StParity: begin
                if (rxd_sync != parity_bit(DataWidthMax'(shift_q), cfg_q.parity_odd)) begin
                  par_pend_d = 1'b1;
                end
                seen_one_d = seen_one_q | rxd_sync;
                state_d    = StStop1;
              end
              StStop1: begin
                if (!rxd_sync) frm_pend_d = 1'b1;
                seen_one_d = seen_one_q | rxd_sync;
                if (cfg_q.stop2) begin
                  state_d = StStop2;
                end else begin
                  state_d  = StIdle;
                  complete = 1'b1;
                end
              end
              StStop2: begin
                // The second stop bit never contributes to break detection.
                if (!rxd_sync) frm_pend_d = 1'b1;
                state_d  = StIdle;
                complete = 1'b1;
              end
              default: state_d = StIdle;
            endcase
          end
        end
      endcase
    end

    valid_d   = valid_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    brk_d     = brk_q;
    overrun_d = 1'b0;
    // A consumer handshake in the completion cycle frees the slot in time.
    if (complete && (!valid_q || ready_i)) begin
      valid_d   = 1'b1;
      data_d    = shift_q;
      par_err_d = par_pend_d;
      frm_err_d = frm_pend_d;
      brk_d     = !seen_one_d;
    end else begin
      overrun_d = complete;
      if (ready_i) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rxd_prev_q <= 1'b1;
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cfg_q      <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      seen_one_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxd_prev_q <= rxd_prev_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      seen_one_q <= seen_one_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      brk_q      <= brk_d;
      overrun_q  <= overrun_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign parity_err_o = par_err_q;
  assign frame_err_o  = frm_err_q;
  assign break_o      = brk_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8-bit and a 7-bit receiver share clock, ticks
// and configuration. Expected frames go into per-instance queues; a monitor
// pops and compares on every valid/ready handshake.
module tb_uart_rx_os;

  localparam int ClkPerTick = 4;
  localparam int Oversample = 16;
  localparam int ClkPerBit  = ClkPerTick * Oversample;
  // Completion edge of an 8N1 frame, counted in negedges from the
  // tick-aligned negedge where its start bit is driven: edge seen 1 tick
  // after sync, start centre 8 ticks later, then 9 bits x 16 ticks.
  localparam int Done8N1    = 612;
  localparam int Frame8N1   = 10 * ClkPerBit;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] div_q = 2'd0;
  logic       baud_tick;
  logic       rst_n;
  logic       rxd8, rxd7;
  logic       par_en, par_odd, stop2;
  logic       ready8, ready7;

  logic       valid8, pe8, fe8, brk8, ovr8, busy8;
  logic [7:0] data8;
  logic       valid7, pe7, fe7, brk7, ovr7, busy7;
  logic [6:0] data7;

  int checks = 0;
  int errors = 0;
  int ovr8_cycles = 0;
  int ovr7_cycles = 0;
  exp_t q8[$];
  exp_t q7[$];

  always #5 clk = ~clk;
  always @(posedge clk) div_q <= div_q + 2'd1;
  assign baud_tick = (div_q == 2'd3);

  uart_rx_os #(.DataWidth(8), .Oversample(Oversample)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .baud_tick_i(baud_tick), .rxd_i(rxd8),
    .parity_en_i(par_en), .parity_odd_i(par_odd), .stop2_i(stop2),
    .ready_i(ready8), .valid_o(valid8), .data_o(data8),
    .parity_err_o(pe8), .frame_err_o(fe8), .break_o(brk8),
    .overrun_o(ovr8), .busy_o(busy8)
  );

  uart_rx_os #(.DataWidth(7), .Oversample(Oversample)) u_dut7 (
    .clk_i(clk), .rst_ni(rst_n), .baud_tick_i(baud_tick), .rxd_i(rxd7),
    .parity_en_i(par_en), .parity_odd_i(par_odd), .stop2_i(stop2),
    .ready_i(ready7), .valid_o(valid7), .data_o(data7),
    .parity_err_o(pe7), .frame_err_o(fe7), .break_o(brk7),
    .overrun_o(ovr7), .busy_o(busy7)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted frame against the head of its queue.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (valid8 && ready8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame8 actual=%h required=no frame", data8);
      end else begin
        e = q8.pop_front();
        check("frame8", {20'd0, 1'b0, data8, pe8, fe8, brk8}, {20'd0, e});
      end
    end
    if (valid7 && ready7) begin
      if (q7.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame7 actual=%h required=no frame", data7);
      end else begin
        e = q7.pop_front();
        check("frame7", {20'd0, 2'b0, data7, pe7, fe7, brk7}, {20'd0, e});
      end
    end
    if (ovr8) ovr8_cycles++;
    if (ovr7) ovr7_cycles++;
  end

  task automatic idle_bits(input int n);
    repeat (n * ClkPerBit) @(negedge clk);
  endtask

  // Returns on a negedge whose following posedge carries a baud tick.
  task automatic align_tick();
    @(negedge clk);
    while (!baud_tick) @(negedge clk);
  endtask

  task automatic drive_bit(input bit to7, input logic v);
    if (to7) rxd7 = v;
    else     rxd8 = v;
    repeat (ClkPerBit) @(negedge clk);
  endtask

  task automatic send_frame(input bit to7, input logic [8:0] d, input int nbits,
                            input bit has_par, input logic par_v,
                            input logic stop1_v, input bit two_stop,
                            input logic stop2_v);
    drive_bit(to7, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(to7, d[i]);
    if (has_par) drive_bit(to7, par_v);
    drive_bit(to7, stop1_v);
    if (two_stop) drive_bit(to7, stop2_v);
    if (to7) rxd7 = 1'b1;
    else     rxd8 = 1'b1;
  endtask

  task automatic frame_8n1(input logic [7:0] d);
    send_frame(1'b0, {1'b0, d}, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rxd8 = 1'b1; rxd7 = 1'b1;
    ready8 = 1'b1; ready7 = 1'b1;
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid8", {31'd0, valid8}, 32'd0);
    check("reset_data8", {24'd0, data8}, 32'd0);
    check("reset_flags8", {27'd0, pe8, fe8, brk8, ovr8, busy8}, 32'd0);
    check("reset_all7", {21'd0, valid7, data7, pe7, fe7, brk7}, 32'd0);

    // 8N1 0xA5
    q8.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
    align_tick();
    frame_8n1(8'hA5);
    check("busy_after_8n1", {31'd0, busy8}, 32'd0);
    idle_bits(2);

    // 8E1, 0x03 has even weight so the correct bit is 0; send 1
    par_en = 1'b1; par_odd = 1'b0;
    q8.push_back('{9'h003, 1'b1, 1'b0, 1'b0});
    align_tick();
    send_frame(1'b0, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_bits(2);

    // 8O1, correct odd parity bit for 0x03 is 1
    par_odd = 1'b1;
    q8.push_back('{9'h003, 1'b0, 1'b0, 1'b0});
    align_tick();
    send_frame(1'b0, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    par_en = 1'b0; par_odd = 1'b0;

    // 7N2 0x55 with second stop low: framing error, not a break
    stop2 = 1'b1;
    q7.push_back('{9'h055, 1'b0, 1'b1, 1'b0});
    align_tick();
    send_frame(1'b1, 9'h055, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(3);
    stop2 = 1'b0;
    check("busy7_after_7n2", {31'd0, busy7}, 32'd0);

    // 5-tick low glitch: false start
    align_tick();
    rxd8 = 1'b0;
    repeat (5 * ClkPerTick) @(negedge clk);
    rxd8 = 1'b1;
    check("glitch_busy", {31'd0, busy8}, 32'd1);
    idle_bits(1);
    check("glitch_busy_clear", {31'd0, busy8}, 32'd0);
    idle_bits(1);

    // Line low for two frame times: one break frame, no retrigger
    q8.push_back('{9'h000, 1'b0, 1'b1, 1'b1});
    align_tick();
    rxd8 = 1'b0;
    repeat (2 * Frame8N1) @(negedge clk);
    check("break_no_retrigger", {31'd0, busy8}, 32'd0);
    rxd8 = 1'b1;
    idle_bits(2);
    q8.push_back('{9'h05A, 1'b0, 1'b0, 1'b0});
    align_tick();
    frame_8n1(8'h5A);
    idle_bits(2);

    // Back-to-back with no consumer: second frame dropped
    ready8 = 1'b0;
    q8.push_back('{9'h011, 1'b0, 1'b0, 1'b0});
    align_tick();
    frame_8n1(8'h11);
    frame_8n1(8'h22);
    idle_bits(1);
    check("overrun_once", ovr8_cycles, 32'd1);
    check("held_data_kept", {24'd0, data8}, 32'h11);
    ready8 = 1'b1;
    idle_bits(1);

    // Back-to-back, consumer ready exactly in the second completion cycle
    ready8 = 1'b0;
    q8.push_back('{9'h011, 1'b0, 1'b0, 1'b0});
    q8.push_back('{9'h022, 1'b0, 1'b0, 1'b0});
    align_tick();
    fork
      begin
        frame_8n1(8'h11);
        frame_8n1(8'h22);
      end
      begin
        repeat (Frame8N1 + Done8N1) @(negedge clk);
        ready8 = 1'b1;
        @(negedge clk);
        ready8 = 1'b0;
      end
    join
    idle_bits(1);
    check("no_overrun_on_accept", ovr8_cycles, 32'd1);
    check("second_loaded", {31'd0, valid8, data8}, {23'd0, 1'b1, 8'h22});
    ready8 = 1'b1;
    idle_bits(1);

    // Reset in the middle of the data bits
    ready8 = 1'b0;
    align_tick();
    frame_8n1(8'h3C);
    idle_bits(1);
    check("held_before_reset", {23'd0, valid8, data8}, {23'd0, 1'b1, 8'h3C});
    align_tick();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    check("busy_mid_frame", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    rxd8  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_mid_frame", {18'd0, valid8, data8, pe8, fe8, brk8, ovr8, busy8}, 32'd0);
    ready8 = 1'b1;
    idle_bits(2);
    q8.push_back('{9'h07E, 1'b0, 1'b0, 1'b0});
    align_tick();
    frame_8n1(8'h7E);
    idle_bits(2);

    check("pending8", q8.size(), 32'd0);
    check("pending7", q7.size(), 32'd0);
    check("overrun7_none", ovr7_cycles, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
